// File: rtl/frequency_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over GATE_CYCLES clocks.
// Define FREQ_METER_OVERFLOW_EN to saturate the edge counter and expose the overflow flag.
module frequency_meter #(
   parameter int GATE_CYCLES = 12000000,
   parameter int COUNT_WIDTH = 24
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sig_in,
   input  logic                   start,
   output logic                   busy,
   output logic                   done_tick,
   output logic [COUNT_WIDTH-1:0] freq
`ifdef FREQ_METER_OVERFLOW_EN
   ,
   output logic                   overflow
`endif
);

   localparam int GW = $clog2(GATE_CYCLES);

   typedef enum logic {IDLE = 1'b0, GATE = 1'b1} state_t;

   state_t                 state, state_next;
   logic                   sync1, sync2, sync3, edge_pulse;
   logic [GW-1:0]          gate_cnt;
   logic [COUNT_WIDTH-1:0] edge_cnt, edge_next;
   logic                   last;

   // Two-flop synchronizer followed by a registered rising-edge detector.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         sync3      <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         sync1      <= sig_in;
         sync2      <= sync1;
         sync3      <= sync2;
         edge_pulse <= sync2 & ~sync3;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = GATE;
         GATE:    if (last)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == GATE);
   end

   assign last = (state == GATE) && (gate_cnt == GW'(GATE_CYCLES - 1));

`ifdef FREQ_METER_OVERFLOW_EN
   logic sat, sat_next, edge_full;

   assign edge_full = &edge_cnt;
   assign edge_next = edge_full ? edge_cnt : edge_cnt + COUNT_WIDTH'(edge_pulse);
   assign sat_next  = sat | (edge_full & edge_pulse);

   always_ff @(posedge clk) begin
      if (reset) begin
         sat      <= 1'b0;
         overflow <= 1'b0;
      end else if (state == IDLE) begin
         if (start) sat <= 1'b0;
      end else begin
         sat <= sat_next;
         if (last) overflow <= sat_next;
      end
   end
`else
   assign edge_next = edge_cnt + COUNT_WIDTH'(edge_pulse);
`endif

   // The final gate cycle's edge pulse is folded straight into the latched result.
   always_ff @(posedge clk) begin
      if (reset) begin
         gate_cnt  <= '0;
         edge_cnt  <= '0;
         freq      <= '0;
         done_tick <= 1'b0;
      end else begin
         done_tick <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               gate_cnt <= '0;
               edge_cnt <= '0;
            end
         end else begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= edge_next;
            if (last) begin
               freq      <= edge_next;
               done_tick <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_frequency_meter.sv
// Scoreboard bench: stimulus queues expected results, monitors compare on done_tick.
module tb_frequency_meter;

   localparam int GATE = 100;

   logic       clk = 1'b0;
   logic       reset, sig_in, start, start2;
   logic       busy, done_tick, busy2, done_tick2;
   logic [23:0] freq;
   logic [2:0]  freq2;
`ifdef FREQ_METER_OVERFLOW_EN
   logic       overflow, overflow2;
`endif

   int checks = 0;
   int failures = 0;
   int mode = 0;
   int ph = 0;
   int run = 0;

   logic [23:0] q1[$];
   logic [3:0]  q2[$];   // {overflow, freq}

   always #5 clk = ~clk;

   frequency_meter #(.GATE_CYCLES(GATE), .COUNT_WIDTH(24)) dut (
      .clk(clk), .reset(reset), .sig_in(sig_in), .start(start),
      .busy(busy), .done_tick(done_tick), .freq(freq)
`ifdef FREQ_METER_OVERFLOW_EN
      , .overflow(overflow)
`endif
   );

   frequency_meter #(.GATE_CYCLES(GATE), .COUNT_WIDTH(3)) dut_small (
      .clk(clk), .reset(reset), .sig_in(sig_in), .start(start2),
      .busy(busy2), .done_tick(done_tick2), .freq(freq2)
`ifdef FREQ_METER_OVERFLOW_EN
      , .overflow(overflow2)
`endif
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Signal source: 0 = held low, 1 = period 10, 2 = period 2
   initial begin
      sig_in = 1'b0;
      forever begin
         @(negedge clk);
         ph++;
         case (mode)
            1:       sig_in = ((ph % 10) < 5);
            2:       sig_in = ph[0];
            default: sig_in = 1'b0;
         endcase
      end
   end

   // Monitor for the wide instance: result value and gate length
   always @(negedge clk) begin
      if (busy) run++;
      else begin
         if (done_tick) begin
            check("gate_len", run, GATE);
            if (q1.size() == 0) check("unexpected_done", 1, 0);
            else check("freq", freq, q1.pop_front());
         end
         run = 0;
      end
   end

   always @(negedge clk) begin
      if (done_tick2) begin
         if (q2.size() == 0) check("unexpected_done_small", 1, 0);
         else begin
            logic [3:0] e;
            e = q2.pop_front();
            check("freq_small", freq2, e[2:0]);
`ifdef FREQ_METER_OVERFLOW_EN
            check("overflow_small", overflow2, e[3]);
`endif
         end
      end
   end

   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start(input logic [23:0] exp);
      q1.push_back(exp);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      bit seen;
      reset = 1'b1; start = 1'b0; start2 = 1'b0;
      ticks(3);
      reset = 1'b0;
      ticks(1);
      check("rst_busy", busy, 0);
      check("rst_done", done_tick, 0);
      check("rst_freq", freq, 0);
      check("rst_freq_small", freq2, 0);
`ifdef FREQ_METER_OVERFLOW_EN
      check("rst_overflow", overflow, 0);
`endif

      // Period-10 square wave: 10 edges per gate
      mode = 1;
      ticks(30);
      pulse_start(24'd10);
      check("busy_after_start", busy, 1);
      ticks(120);

      // Held low: zero edges
      mode = 0;
      ticks(10);
      pulse_start(24'd0);
      ticks(120);

      // Mid-gate start ignored, then back-to-back start on done_tick
      mode = 1;
      ticks(30);
      pulse_start(24'd10);
      ticks(49);
      start = 1'b1;
      ticks(1);
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (done_tick) seen = 1'b1;
      end
      check("done_seen", seen, 1);
      pulse_start(24'd10);
      check("b2b_busy", busy, 1);
      ticks(120);
      check("held_freq", freq, 10);

      // Reset mid-gate aborts; reset wins over a coincident start
      pulse_start(24'd0);
      void'(q1.pop_back());
      ticks(39);
      reset = 1'b1;
      start = 1'b1;
      ticks(1);
      reset = 1'b0;
      start = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_freq", freq, 0);
      ticks(120);
      check("abort_busy_later", busy, 0);

      // Narrow counter with period-2 input: 50 edges
      mode = 2;
      ticks(10);
`ifdef FREQ_METER_OVERFLOW_EN
      q2.push_back({1'b1, 3'd7});
`else
      q2.push_back({1'b0, 3'd2});
`endif
      start2 = 1'b1;
      ticks(1);
      start2 = 1'b0;
      ticks(120);

      check("q1_drained", q1.size(), 0);
      check("q2_drained", q2.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
